// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace buffer: state encoding,
// capture-flag bit positions and the record-width helper.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_POST    = 2'b10,
    ST_DONE    = 2'b11
  } trace_state_e;

  localparam int FLAGS_W       = 5;
  localparam int FLAG_MEMWRITE = 0;
  localparam int FLAG_MEMREAD  = 1;
  localparam int FLAG_BRANCH   = 2;
  localparam int FLAG_REGWRITE = 3;
  localparam int FLAG_ZERO     = 4;

  // Record is {pc, instr, alu, flags} with pc in the MSBs.
  function automatic int rec_w(input int data_w);
    return 3 * data_w + FLAGS_W;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage: one write port and one registered read port. Only the
// read register is reset; the array contents survive reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_buffer.sv
// Circular trace buffer for retired-instruction records with halt/PC trigger,
// post-trigger capture window and oldest-first readout once capture is done.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int REC_W    = rec_w(DATA_W),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_pc,
  input  logic [DATA_W-1:0] cap_instr,
  input  logic [DATA_W-1:0] cap_alu,
  input  logic [4:0]        cap_flags,
  input  logic              halt,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              trig_pc_en,
  output logic [1:0]        state,
  output logic              triggered,
  output logic [CNT_W-1:0]  count,
  input  logic              rd_en,
  output logic [REC_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trace_buffer: DEPTH must be a power of two >= 2");
  end
  if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1) begin : g_bad_post
    $error("trace_buffer: POST_TRIG must be in 0..DEPTH-1");
  end

  trace_state_e    state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            trig_q, trig_d;
  logic            rd_valid_q, rd_valid_d;
  logic            store, trigger, enter_done, ram_re;

  assign trigger = cap_valid && (halt || (trig_pc_en && (cap_pc == trig_pc)));
  assign store   = cap_valid && (state_q == ST_CAPTURE || state_q == ST_POST);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_cnt_d = post_cnt_q;
    count_d    = count_q;
    trig_d     = trig_q;
    rd_valid_d = 1'b0;
    ram_re     = 1'b0;
    enter_done = 1'b0;

    if (store) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != COUNT_FULL) count_d = count_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          count_d  = '0;
          trig_d   = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (trigger) begin
          trig_d = 1'b1;
          if (POST_TRIG == 0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d    = ST_POST;
            post_cnt_d = AW'(POST_TRIG);
          end
        end
      end
      ST_POST: begin
        if (cap_valid) begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // arm wins over a same-cycle read
        if (arm) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          count_d  = '0;
          trig_d   = 1'b0;
        end else if (rd_en && count_q != '0) begin
          ram_re     = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          count_d    = count_q - CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Oldest record sits count slots behind the write pointer; a full buffer
    // gives count mod DEPTH == 0, i.e. the slot about to be overwritten.
    if (enter_done) rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      count_q    <= count_d;
      trig_q     <= trig_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(REC_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i ({cap_pc, cap_instr, cap_alu, cap_flags}),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign state     = state_q;
  assign triggered = trig_q;
  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign rd_empty  = (count_q == '0);

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: three instances (POST_TRIG 2, 1, 0) share
// one stimulus bus; each scenario checks the instance it targets.
module tb_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int REC_W = 3 * DW + 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          arm;
  logic          cap_valid;
  logic [DW-1:0] cap_pc, cap_instr, cap_alu, trig_pc;
  logic [4:0]    cap_flags;
  logic          halt, trig_pc_en, rd_en;

  logic [1:0]       st       [3];
  logic             trg      [3];
  logic [CW-1:0]    cnt      [3];
  logic [REC_W-1:0] rdat     [3];
  logic             rv       [3];
  logic             emp      [3];

  logic [REC_W-1:0] exp_q[$];
  int checks;
  int errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(2)) u_a (
    .clk(clk), .reset(reset), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_alu(cap_alu), .cap_flags(cap_flags), .halt(halt),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .state(st[0]), .triggered(trg[0]),
    .count(cnt[0]), .rd_en(rd_en), .rd_data(rdat[0]), .rd_valid(rv[0]), .rd_empty(emp[0]));

  trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(1)) u_b (
    .clk(clk), .reset(reset), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_alu(cap_alu), .cap_flags(cap_flags), .halt(halt),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .state(st[1]), .triggered(trg[1]),
    .count(cnt[1]), .rd_en(rd_en), .rd_data(rdat[1]), .rd_valid(rv[1]), .rd_empty(emp[1]));

  trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(0)) u_c (
    .clk(clk), .reset(reset), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_alu(cap_alu), .cap_flags(cap_flags), .halt(halt),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .state(st[2]), .triggered(trg[2]),
    .count(cnt[2]), .rd_en(rd_en), .rd_data(rdat[2]), .rd_valid(rv[2]), .rd_empty(emp[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [DW-1:0] pc);
    logic [DW-1:0] instr;
    instr = pc + 32'h1000;
    return {pc, instr, ~pc, pc[6:2]};
  endfunction

  // driver tasks: each starts and ends on a falling edge
  task automatic cap(input logic [DW-1:0] pc, input logic h);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = pc + 32'h1000;
    cap_alu   = ~pc;
    cap_flags = pc[6:2];
    halt      = h;
    @(negedge clk);
    cap_valid = 1'b0;
    halt      = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_one(input int which, input string tag);
    logic [REC_W-1:0] exp;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 128'd0, 128'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_valid"}, 128'(rv[which]), 128'd1);
      chk({tag, "_data"}, 128'(rdat[which]), 128'(exp));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    arm = 0; cap_valid = 0; cap_pc = '0; cap_instr = '0; cap_alu = '0;
    cap_flags = '0; halt = 0; trig_pc = '0; trig_pc_en = 0; rd_en = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_state", 128'(st[0]), 128'd0);
    chk("rst_count", 128'(cnt[0]), 128'd0);
    chk("rst_trig", 128'(trg[0]), 128'd0);
    chk("rst_rvalid", 128'(rv[0]), 128'd0);
    chk("rst_empty", 128'(emp[0]), 128'd1);
    chk("rst_rdata", 128'(rdat[0]), 128'd0);
    reset = 1'b1;
    @(negedge clk);

    // basic capture, POST_TRIG=2
    pulse_arm();
    chk("b_capture", 128'(st[0]), 128'd1);
    for (int pc = 0; pc < 16; pc += 4) cap(32'(pc), 1'b0);
    chk("b_pre_trig", 128'(trg[0]), 128'd0);
    cap(32'd16, 1'b1);
    chk("b_post", 128'(st[0]), 128'd2);
    chk("b_trig", 128'(trg[0]), 128'd1);
    chk("b_cnt5", 128'(cnt[0]), 128'd5);
    pulse_arm();
    chk("b_arm_in_post", 128'(st[0]), 128'd2);
    chk("b_arm_cnt", 128'(cnt[0]), 128'd5);
    cap(32'd20, 1'b0);
    chk("b_post2", 128'(st[0]), 128'd2);
    cap(32'd24, 1'b0);
    chk("b_done", 128'(st[0]), 128'd3);
    chk("b_cnt7", 128'(cnt[0]), 128'd7);
    @(negedge clk);
    chk("b_hold", 128'(cnt[0]), 128'd7);
    for (int pc = 0; pc <= 24; pc += 4) exp_q.push_back(mk_rec(32'(pc)));
    for (int i = 0; i < 7; i++) read_one(0, "b_rd");
    chk("b_empty", 128'(emp[0]), 128'd1);
    chk("b_cnt0", 128'(cnt[0]), 128'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("b_rd_empty_valid", 128'(rv[0]), 128'd0);
    chk("b_rd_empty_state", 128'(st[0]), 128'd3);

    // wrap, POST_TRIG=1
    do_reset();
    pulse_arm();
    for (int pc = 0; pc < 72; pc += 4) cap(32'(pc), 1'b0);
    cap(32'd72, 1'b1);
    chk("w_post", 128'(st[1]), 128'd2);
    cap(32'd76, 1'b0);
    chk("w_done", 128'(st[1]), 128'd3);
    chk("w_cnt8", 128'(cnt[1]), 128'd8);
    for (int pc = 48; pc <= 76; pc += 4) exp_q.push_back(mk_rec(32'(pc)));
    for (int i = 0; i < 8; i++) read_one(1, "w_rd");
    chk("w_empty", 128'(emp[1]), 128'd1);

    // PC-match trigger, POST_TRIG=0
    do_reset();
    trig_pc    = 32'h40;
    trig_pc_en = 1'b1;
    pulse_arm();
    cap(32'h38, 1'b0);
    cap(32'h3c, 1'b0);
    chk("p_capture", 128'(st[2]), 128'd1);
    chk("p_no_trig", 128'(trg[2]), 128'd0);
    cap(32'h40, 1'b0);
    chk("p_done", 128'(st[2]), 128'd3);
    chk("p_trig", 128'(trg[2]), 128'd1);
    chk("p_cnt3", 128'(cnt[2]), 128'd3);
    cap(32'h44, 1'b0);
    chk("p_no_write_done", 128'(cnt[2]), 128'd3);
    exp_q.push_back(mk_rec(32'h38));
    read_one(2, "p_rd");
    chk("p_cnt2", 128'(cnt[2]), 128'd2);
    arm   = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    arm   = 1'b0;
    rd_en = 1'b0;
    chk("p_arm_rd_state", 128'(st[2]), 128'd1);
    chk("p_arm_rd_valid", 128'(rv[2]), 128'd0);
    chk("p_arm_rd_cnt", 128'(cnt[2]), 128'd0);
    chk("p_arm_rd_trig", 128'(trg[2]), 128'd0);

    // asynchronous reset while u_a sits in POST
    chk("r_in_post", 128'(st[0]), 128'd2);
    chk("r_cnt_pre", 128'(cnt[0]), 128'd4);
    #2 reset = 1'b0;
    #1;
    chk("r_state", 128'(st[0]), 128'd0);
    chk("r_count", 128'(cnt[0]), 128'd0);
    chk("r_trig", 128'(trg[0]), 128'd0);
    chk("r_rvalid", 128'(rv[0]), 128'd0);
    chk("r_rdata_c", 128'(rdat[2]), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
